// File: rtl/jcr_int_ctrl.sv
// Memory-mapped interrupt controller for the jacaranda-8 CPU: edge-triggered
// pending bits, per-source masking, fixed-priority arbitration and EOI handshake.
module jcr_int_ctrl #(
  parameter int unsigned NSRC       = 4,
  parameter logic [7:0]  ADDR_VEC0  = 8'd240,
  parameter logic [7:0]  ADDR_EOI   = 8'd244,
  parameter logic [7:0]  ADDR_ISRC  = 8'd245,
  parameter logic [7:0]  ADDR_IPEND = 8'd246,
  parameter logic [7:0]  ADDR_IMASK = 8'd247
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [7:0]      access_addr,
  input  logic [7:0]      w_data,
  input  logic            mem_w_en,
  output logic [7:0]      r_data,
  output logic            r_hit,
  input  logic [NSRC-1:0] irq_src,
  output logic            int_req,
  output logic [7:0]      int_vec,
  output logic            int_en
);

  typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;

  state_t          state_q, state_d;
  logic [NSRC-1:0] imask_q, imask_d;
  logic [NSRC-1:0] ipend_q, ipend_d;
  logic [NSRC-1:0] prev_q;
  logic [NSRC-1:0] rise, elig;
  logic            gie_q, gie_d;
  logic [7:0]      vec_q [NSRC];
  logic [2:0]      sel_q, sel_d;
  logic [7:0]      int_vec_q, int_vec_d;
  logic            wr_eoi, wr_ipend, wr_imask;

  assign rise     = irq_src & ~prev_q;
  assign elig     = ipend_q & imask_q & {NSRC{gie_q}};
  assign wr_eoi   = mem_w_en && (access_addr == ADDR_EOI);
  assign wr_ipend = mem_w_en && (access_addr == ADDR_IPEND);
  assign wr_imask = mem_w_en && (access_addr == ADDR_IMASK);

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    int_vec_d = int_vec_q;
    case (state_q)
      IDLE: begin
        if (|elig) begin
          state_d = REQ;
          // Scan downward so the lowest eligible index is the last to win.
          for (int unsigned i = NSRC; i > 0; i--) begin
            if (elig[i-1]) begin
              sel_d     = 3'(i-1);
              int_vec_d = vec_q[i-1];
            end
          end
        end
      end
      REQ:     state_d = SVC;
      SVC:     if (wr_eoi) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ipend_d = ipend_q;
    imask_d = imask_q;
    gie_d   = gie_q;
    if (wr_ipend) ipend_d = ipend_d & ~w_data[NSRC-1:0];
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (state_q == REQ && sel_q == 3'(i)) ipend_d[i] = 1'b0;
    end
    // New edges are applied last so a set beats any clear in the same cycle.
    ipend_d = ipend_d | rise;
    if (wr_imask) begin
      imask_d = w_data[NSRC-1:0];
      gie_d   = w_data[7];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      imask_q   <= '0;
      gie_q     <= 1'b0;
      ipend_q   <= '0;
      prev_q    <= '0;
      sel_q     <= '0;
      int_vec_q <= '0;
      for (int unsigned i = 0; i < NSRC; i++) vec_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      imask_q   <= imask_d;
      gie_q     <= gie_d;
      ipend_q   <= ipend_d;
      prev_q    <= irq_src;
      sel_q     <= sel_d;
      int_vec_q <= int_vec_d;
      for (int unsigned i = 0; i < NSRC; i++) begin
        if (mem_w_en && access_addr == ADDR_VEC0 + 8'(i)) vec_q[i] <= w_data;
      end
    end
  end

  always_comb begin
    r_hit  = (access_addr >= ADDR_VEC0) && (access_addr <= ADDR_IMASK);
    r_data = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (access_addr == ADDR_VEC0 + 8'(i)) r_data = vec_q[i];
    end
    case (access_addr)
      ADDR_ISRC:  r_data = {state_q != IDLE, 4'b0000, sel_q};
      ADDR_IPEND: r_data[NSRC-1:0] = ipend_q;
      ADDR_IMASK: begin
        r_data[7]        = gie_q;
        r_data[NSRC-1:0] = imask_q;
      end
      default: ;
    endcase
  end

  assign int_req = (state_q == REQ);
  assign int_en  = (state_q != SVC);
  assign int_vec = int_vec_q;

endmodule

// File: tb/tb_jcr_int_ctrl.sv
// Scoreboard bench for jcr_int_ctrl: a reference model queues each expected
// service vector; a negedge monitor pops on int_req and checks the outputs.
module tb_jcr_int_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] access_addr = '0;
  logic [7:0] w_data = '0;
  logic       mem_w_en = 1'b0;
  logic [7:0] r_data;
  logic       r_hit;
  logic [3:0] irq_src = '0;
  logic       int_req;
  logic [7:0] int_vec;
  logic       int_en;

  int vectors = 0;
  int miscompares = 0;
  int svc_cnt = 0;

  always #5 clock = ~clock;

  jcr_int_ctrl #(
    .NSRC      (4),
    .ADDR_VEC0 (8'd240),
    .ADDR_EOI  (8'd244),
    .ADDR_ISRC (8'd245),
    .ADDR_IPEND(8'd246),
    .ADDR_IMASK(8'd247)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .access_addr(access_addr),
    .w_data     (w_data),
    .mem_w_en   (mem_w_en),
    .r_data     (r_data),
    .r_hit      (r_hit),
    .irq_src    (irq_src),
    .int_req    (int_req),
    .int_vec    (int_vec),
    .int_en     (int_en)
  );

  // Reference model: phase 0 = waiting, 1 = request cycle, 2 = in service.
  int         m_phase = 0;
  logic [3:0] m_mask = '0, m_pend = '0, m_prev = '0;
  logic       m_gie = 1'b0;
  logic [2:0] m_cur = '0;
  logic [7:0] m_ivec = '0;
  logic [7:0] m_vec [4] = '{default: 8'h00};
  logic [7:0] exp_q [$];

  always @(posedge clock) begin : model
    logic [3:0] rise, elig, np;
    int k;
    int wi;
    if (reset) begin
      m_phase <= 0;
      m_mask  <= '0;
      m_gie   <= 1'b0;
      m_pend  <= '0;
      m_prev  <= '0;
      m_cur   <= '0;
      m_ivec  <= '0;
      m_vec   <= '{default: 8'h00};
    end else begin
      rise = irq_src & ~m_prev;
      elig = m_pend & m_mask & {4{m_gie}};
      np   = m_pend;
      m_prev <= irq_src;
      if (m_phase == 0) begin
        if (elig != 0) begin
          k = 0;
          while (!elig[k]) k++;
          m_cur  <= 3'(k);
          m_ivec <= m_vec[k];
          exp_q.push_back(m_vec[k]);
          m_phase <= 1;
        end
      end else if (m_phase == 1) begin
        np[m_cur[1:0]] = 1'b0;
        m_phase <= 2;
      end else if (mem_w_en && access_addr == 8'd244) begin
        m_phase <= 0;
      end
      if (mem_w_en) begin
        if (access_addr >= 8'd240 && access_addr <= 8'd243) begin
          wi = int'(access_addr) - 240;
          m_vec[wi] <= w_data;
        end
        if (access_addr == 8'd246) np = np & ~w_data[3:0];
        if (access_addr == 8'd247) begin
          m_gie  <= w_data[7];
          m_mask <= w_data[3:0];
        end
      end
      m_pend <= np | rise;
    end
  end

  function automatic logic [8:0] model_read(input logic [7:0] a);
    logic [7:0] d;
    logic h;
    int ri;
    d = '0;
    h = (a >= 8'd240) && (a <= 8'd247);
    if (a >= 8'd240 && a <= 8'd243) begin
      ri = int'(a) - 240;
      d = m_vec[ri];
    end else if (a == 8'd245) d = {m_phase != 0, 4'b0000, m_cur};
    else if (a == 8'd246) d = {4'b0000, m_pend};
    else if (a == 8'd247) d = {m_gie, 3'b000, m_mask};
    return {h, d};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    chk("int_req", 8'(int_req), 8'(m_phase == 1));
    chk("int_en", 8'(int_en), 8'(m_phase != 2));
    chk("int_vec", int_vec, m_ivec);
    if (int_req === 1'b1) begin
      svc_cnt++;
      chk("sb_depth", 8'(exp_q.size()), 8'd1);
      if (exp_q.size() > 0) chk("sb_vec", int_vec, exp_q.pop_front());
    end
  end

  task automatic step(input logic [3:0] irq, input logic we, input logic [7:0] addr,
                      input logic [7:0] d);
    logic [8:0] e;
    @(negedge clock);
    reset       = 1'b0;
    irq_src     = irq;
    mem_w_en    = we;
    access_addr = addr;
    w_data      = d;
    #1;
    e = model_read(addr);
    chk("r_hit", 8'(r_hit), 8'(e[8]));
    chk("r_data", r_data, e[7:0]);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset    = 1'b1;
    irq_src  = '0;
    mem_w_en = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int base;
    logic [7:0] a, d;
    repeat (2) @(negedge clock);

    // Reset values
    step(4'h0, 1'b0, 8'd247, 8'h00); chk("rst_imask", r_data, 8'h00);
    step(4'h0, 1'b0, 8'd246, 8'h00); chk("rst_ipend", r_data, 8'h00);
    step(4'h0, 1'b0, 8'd245, 8'h00); chk("rst_isrc", r_data, 8'h00);
    chk("rst_int_en", 8'(int_en), 8'h01);
    chk("rst_int_req", 8'(int_req), 8'h00);
    step(4'h0, 1'b0, 8'd100, 8'h00); chk("miss_hit", 8'(r_hit), 8'h00);

    // Single source, latency and service
    step(4'h0, 1'b1, 8'd241, 8'h40);
    step(4'h0, 1'b1, 8'd247, 8'h82);
    step(4'h2, 1'b0, 8'd245, 8'h00);
    step(4'h0, 1'b0, 8'd246, 8'h00); chk("lat_pend", r_data, 8'h02);
    chk("lat_noreq", 8'(int_req), 8'h00);
    step(4'h0, 1'b0, 8'd245, 8'h00); chk("req_isrc", r_data, 8'h81);
    chk("req_hi", 8'(int_req), 8'h01); chk("req_vec", int_vec, 8'h40);
    step(4'h0, 1'b0, 8'd246, 8'h00); chk("svc_pend", r_data, 8'h00);
    chk("svc_en", 8'(int_en), 8'h00); chk("svc_req", 8'(int_req), 8'h00);
    step(4'h0, 1'b0, 8'd245, 8'h00); chk("svc_isrc", r_data, 8'h81);
    step(4'h0, 1'b1, 8'd244, 8'h5A);
    step(4'h0, 1'b0, 8'd245, 8'h00); chk("eoi_isrc", r_data, 8'h01);
    chk("eoi_en", 8'(int_en), 8'h01);

    // Simultaneous rises, priority and back-to-back
    step(4'h0, 1'b1, 8'd240, 8'h10);
    step(4'h0, 1'b1, 8'd243, 8'h33);
    step(4'h0, 1'b1, 8'd247, 8'h8F);
    step(4'h9, 1'b0, 8'd245, 8'h00);
    step(4'h0, 1'b0, 8'd246, 8'h00); chk("sim_pend", r_data, 8'h09);
    step(4'h0, 1'b0, 8'd245, 8'h00); chk("sim_isrc0", r_data, 8'h80);
    chk("sim_vec0", int_vec, 8'h10);
    step(4'h0, 1'b0, 8'd246, 8'h00); chk("sim_pend3", r_data, 8'h08);
    step(4'h0, 1'b1, 8'd244, 8'h00);
    step(4'h0, 1'b0, 8'd245, 8'h00); chk("b2b_idle", r_data, 8'h00);
    step(4'h0, 1'b0, 8'd245, 8'h00); chk("b2b_isrc3", r_data, 8'h83);
    chk("b2b_vec3", int_vec, 8'h33);
    step(4'h0, 1'b0, 8'd246, 8'h00); chk("b2b_pend", r_data, 8'h00);
    step(4'h0, 1'b1, 8'd244, 8'h00);
    step(4'h0, 1'b0, 8'd245, 8'h00); chk("vec_hold", int_vec, 8'h33);

    // GIE gating and write-1-to-clear vs. rise
    step(4'h0, 1'b1, 8'd247, 8'h01);
    step(4'h1, 1'b0, 8'd246, 8'h00);
    step(4'h0, 1'b0, 8'd246, 8'h00); chk("gie_pend", r_data, 8'h01);
    step(4'h0, 1'b0, 8'd246, 8'h00); chk("gie_noreq", 8'(int_req), 8'h00);
    step(4'h0, 1'b1, 8'd247, 8'h81);
    step(4'h0, 1'b0, 8'd245, 8'h00);
    step(4'h0, 1'b0, 8'd245, 8'h00); chk("gie_req", 8'(int_req), 8'h01);
    chk("gie_isrc", r_data, 8'h80);
    step(4'h0, 1'b1, 8'd244, 8'h00);
    step(4'h0, 1'b1, 8'd247, 8'h00);
    step(4'h1, 1'b0, 8'd246, 8'h00);
    step(4'h0, 1'b1, 8'd246, 8'h01);
    step(4'h0, 1'b0, 8'd246, 8'h00); chk("w1c_clr", r_data, 8'h00);
    step(4'h1, 1'b1, 8'd246, 8'h01);
    step(4'h0, 1'b0, 8'd246, 8'h00); chk("w1c_setwins", r_data, 8'h01);
    step(4'h0, 1'b1, 8'd246, 8'h0F);

    // Held level gives one event; re-rise during service is re-served
    step(4'h0, 1'b1, 8'd242, 8'h22);
    step(4'h0, 1'b1, 8'd247, 8'h84);
    base = svc_cnt;
    repeat (20) step(4'h4, 1'b0, 8'd245, 8'h00);
    step(4'h0, 1'b0, 8'd245, 8'h00); chk("hold_once", 8'(svc_cnt - base), 8'd1);
    step(4'h4, 1'b0, 8'd246, 8'h00);
    step(4'h0, 1'b0, 8'd246, 8'h00); chk("resvc_pend", r_data, 8'h04);
    step(4'h0, 1'b1, 8'd244, 8'h00);
    step(4'h0, 1'b0, 8'd245, 8'h00);
    step(4'h0, 1'b0, 8'd245, 8'h00);
    step(4'h0, 1'b0, 8'd245, 8'h00); chk("resvc_cnt", 8'(svc_cnt - base), 8'd2);
    chk("resvc_isrc", r_data, 8'h82);

    // Reset while in service, then EOI in IDLE
    do_reset();
    step(4'h0, 1'b0, 8'd245, 8'h00); chk("rsvc_isrc", r_data, 8'h00);
    chk("rsvc_en", 8'(int_en), 8'h01);
    step(4'h0, 1'b0, 8'd246, 8'h00); chk("rsvc_pend", r_data, 8'h00);
    step(4'h0, 1'b0, 8'd247, 8'h00); chk("rsvc_mask", r_data, 8'h00);
    step(4'h0, 1'b1, 8'd244, 8'h00);
    step(4'h0, 1'b0, 8'd245, 8'h00); chk("eoi_idle", r_data, 8'h00);
    chk("eoi_idle_en", 8'(int_en), 8'h01);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else if (m_phase == 2 && $urandom_range(0, 3) == 0) begin
        step(4'($urandom & $urandom), 1'b1, 8'd244, 8'($urandom));
      end else if ($urandom_range(0, 3) == 0) begin
        a = 8'(240 + $urandom_range(0, 7));
        d = 8'($urandom);
        if (a == 8'd247 && $urandom_range(0, 1) == 1) d[7] = 1'b1;
        step(4'($urandom & $urandom), 1'b1, a, d);
      end else begin
        a = 8'($urandom_range(234, 252));
        step(4'($urandom & $urandom), 1'b0, a, 8'h00);
      end
    end
    step(4'h0, 1'b0, 8'd100, 8'h00);
    step(4'h0, 1'b0, 8'd100, 8'h00);
    chk("sb_empty", 8'(exp_q.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/jcr_int_ctrl.md
Name: jcr_int_ctrl

Overview:
- Memory-mapped interrupt controller for the jacaranda-8 CPU.
- Collects up to NSRC edge-triggered interrupt sources (UART receive, timer, LED done, ...) and holds them as pending bits, with per-source masking.
- Arbitrates pending sources by fixed priority and presents the CPU with a one-cycle int_req, the selected source's vector, and the int_en gate.
- Replaces the ad-hoc int_vec/int_en logic in the top level; it sits on the same rs_data/rd_data/mem_w_en data-memory access path as the other I/O registers.

Parameters:
- NSRC, 4, number of interrupt sources (1..4); source 0 has the highest priority.
- ADDR_VEC0, 8'd240, address of the vector for source 0; source i's vector is at ADDR_VEC0+i.
- ADDR_EOI, 8'd244, end-of-interrupt register (write-only).
- ADDR_ISRC, 8'd245, in-service status register (read-only).
- ADDR_IPEND, 8'd246, pending register (read; write-1-to-clear).
- ADDR_IMASK, 8'd247, mask register: bit7 = global enable (GIE), bits[NSRC-1:0] = per-source enables.

Ports:
- clock  in  1  system clock (CPU clock domain).
- reset  in  1  synchronous, active-high reset.
- access_addr  in  8  data-memory address (CPU rs_data).
- w_data  in  8  write data (CPU rd_data).
- mem_w_en  in  1  data-memory write strobe.
- r_data  out  8  read data for access_addr (combinational).
- r_hit  out  1  high when access_addr is inside the block's address map (ADDR_VEC0..ADDR_IMASK); the top level uses it to select r_data.
- irq_src  in  NSRC  interrupt source lines, synchronous to clock.
- int_req  out  1  interrupt request pulse to the CPU.
- int_vec  out  8  vector (jump target) of the source being serviced.
- int_en  out  1  interrupt enable to the CPU.

Behaviour:
- Reset, applied at any time including mid-service:
  - clears imask, ipend, all vectors, the irq_src previous-sample register, sel and int_vec to 0;
  - forces state to IDLE, int_req = 0, int_en = 1.
- Edge detection:
  - prev <= irq_src every cycle.
  - rise = irq_src & ~prev.
  - ipend[i] is set at the posedge where rise[i] = 1.
  - A level held high produces exactly one pending event.
- Register writes take effect at the posedge where mem_w_en = 1 and access_addr matches:
  - IMASK: stores w_data[7] and w_data[NSRC-1:0]; all other bits read back as 0.
  - IPEND: clears every bit i where w_data[i] = 1. If the same bit also rises in that cycle, the set wins.
  - Vector addresses: store w_data.
  - EOI: the data value is ignored.
  - Writes to ISRC, and to vector addresses for i >= NSRC, are ignored.
- Reads (combinational):
  - ISRC returns {busy, 4'b0, sel[2:0]}, where busy = 1 when state != IDLE.
  - EOI reads 0.
  - r_hit = 0 outside the address map, with r_data = 0 in that case.
- Eligible set: elig = ipend & imask[NSRC-1:0] & {NSRC{GIE}}.
- State machine:
  - IDLE: int_en = 1, int_req = 0. If elig != 0, at the next posedge latch sel = lowest set index of elig, latch int_vec = vec[sel], then go to REQ.
  - REQ (exactly 1 cycle): int_req = 1, int_en = 1. At the next posedge clear ipend[sel] and go to SVC. A mask or vector write during REQ does not cancel or alter the request.
  - SVC: int_req = 0, int_en = 0. Stay until an EOI write, then go to IDLE at that posedge. New edges continue to set ipend, including on source sel.
- EOI written while in IDLE or REQ: ignored.
- Latency: a rising edge sampled at posedge k sets ipend after k. With the source eligible and the state IDLE, int_req is high for the cycle following posedge k+1. Back-to-back: after the EOI posedge, the next pending source reaches REQ one cycle later.
- Simultaneous rises: the lower index is served first; the higher index remains pending.
- int_vec holds its value after SVC until the next selection.

Test Plan:
- Reset, then read 247/246/245 -> 0x00, 0x00, 0x00. int_en = 1, int_req = 0, r_hit = 0 at address 100.
- Write vec1 = 0x40, IMASK = 0x82; pulse irq_src[1] -> int_req high for exactly 1 cycle, 2 cycles after the edge. int_vec = 0x40, ISRC = 0x81, int_en = 0 until EOI, IPEND = 0 after REQ.
- With IMASK = 0x8F, raise irq_src[3] and irq_src[0] in the same cycle -> source 0 is served first (ISRC = 0x80). After EOI, source 3 is served (ISRC = 0x83, int_vec = vec3).
- With IMASK = 0x01 (GIE = 0), pulse irq_src[0] -> no int_req and IPEND = 0x01. Write IMASK = 0x81 -> int_req fires. Separately: write IPEND = 0x01 in the same cycle as a new rise on source 0 -> IPEND remains 0x01.
- Hold irq_src[2] high for 20 cycles -> exactly one service. A second rise of source 2 during SVC -> re-serviced after EOI.
- Assert reset while in SVC -> state IDLE, int_en = 1, IPEND/IMASK = 0. EOI written in IDLE -> no effect.
